// File: rtl/ncl_add_sequencer.sv
// Clocked sequencer that feeds binary operands to an NCL dual-rail adder array,
// walks it through DATA/NULL wavefronts and returns the captured binary result.
module ncl_add_sequencer #(
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               init,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic [2*WIDTH-1:0] A_dr,
  output logic [2*WIDTH-1:0] B_dr,
  output logic [1:0]         cin_dr,
  input  logic [2*WIDTH-1:0] sum_dr,
  input  logic [1:0]         cout_dr,
  input  logic               ack_comp,
  output logic [1:0]         rx_comp,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic [1:0]         err
);

  typedef enum logic [2:0] {IDLE, DDATA, WDATA, DNULL, WNULL, OUT, ERR} state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic               cin_reg;
  logic               ack_s1, ack_s2;
  logic [2*WIDTH-1:0] sum_s1, sum_s2;
  logic [1:0]         cout_s1, cout_s2;
  logic [15:0]        cnt_reg;

  logic [WIDTH-1:0]   dig_data, dig_null, dig_ill, sum_rail1;
  logic [2*WIDTH-1:0] a_enc, b_enc;
  logic               all_data, all_null, any_ill, tmo_hit;

  // Per-digit classification of the synchronized sum and dual-rail operand encoding
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_digit
      assign dig_data[gi]    = sum_s2[2*gi+1] ^ sum_s2[2*gi];
      assign dig_null[gi]    = ~(sum_s2[2*gi+1] | sum_s2[2*gi]);
      assign dig_ill[gi]     = sum_s2[2*gi+1] & sum_s2[2*gi];
      assign sum_rail1[gi]   = sum_s2[2*gi+1];
      assign a_enc[2*gi+1]   = a_reg[gi];
      assign a_enc[2*gi]     = ~a_reg[gi];
      assign b_enc[2*gi+1]   = b_reg[gi];
      assign b_enc[2*gi]     = ~b_reg[gi];
    end
  endgenerate

  assign all_data = (&dig_data) & (cout_s2[1] ^ cout_s2[0]);
  assign all_null = (&dig_null) & ~(cout_s2[1] | cout_s2[0]);
  assign any_ill  = (|dig_ill) | (&cout_s2);
  assign tmo_hit  = (cnt_reg == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      ack_s1  <= 1'b0;
      ack_s2  <= 1'b0;
      sum_s1  <= '0;
      sum_s2  <= '0;
      cout_s1 <= '0;
      cout_s2 <= '0;
    end else begin
      ack_s1  <= ack_comp;
      ack_s2  <= ack_s1;
      sum_s1  <= sum_dr;
      sum_s2  <= sum_s1;
      cout_s1 <= cout_dr;
      cout_s2 <= cout_s1;
    end
  end

  always_ff @(posedge clk or negedge init) begin
    if (!init) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      A_dr      <= '0;
      B_dr      <= '0;
      cin_dr    <= '0;
      rx_comp   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      err       <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            cin_reg  <= cin;
            in_ready <= 1'b0;
            state    <= DDATA;
          end
        end
        DDATA: begin
          A_dr    <= a_enc;
          B_dr    <= b_enc;
          cin_dr  <= {cin_reg, ~cin_reg};
          cnt_reg <= '0;
          state   <= WDATA;
        end
        WDATA, WNULL: begin
          // Errors take priority over a completion seen in the same cycle
          if (any_ill || tmo_hit) begin
            err     <= err | {any_ill, tmo_hit};
            A_dr    <= '0;
            B_dr    <= '0;
            cin_dr  <= '0;
            rx_comp <= 2'b11;
            state   <= ERR;
          end else if (state == WDATA && ack_s2 && all_data) begin
            sum   <= sum_rail1;
            cout  <= cout_s2[1];
            state <= DNULL;
          end else if (state == WNULL && !ack_s2 && all_null) begin
            rx_comp   <= 2'b00;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        DNULL: begin
          A_dr    <= '0;
          B_dr    <= '0;
          cin_dr  <= '0;
          rx_comp <= 2'b11;
          cnt_reg <= '0;
          state   <= WNULL;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        ERR: begin
          A_dr      <= '0;
          B_dr      <= '0;
          cin_dr    <= '0;
          rx_comp   <= 2'b11;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Randomized bench for ncl_add_sequencer with a behavioural dual-rail adder
// model and an arithmetic reference for every result.
module tb_ncl_add_sequencer;
  localparam int W   = 4;
  localparam int TMO = 30;

  logic           clk = 1'b0;
  logic           init, in_valid, in_ready, cin, cout, ack_comp, out_valid, out_ready;
  logic [W-1:0]   a, b, sum;
  logic [2*W-1:0] A_dr, B_dr, sum_dr;
  logic [1:0]     cin_dr, cout_dr, rx_comp, err;

  int checks = 0;
  int errors = 0;
  int dly_data = 0, dly_null = 0;
  int mode = 0;               // 0 normal adder, 1 never completes, 2 corrupt digit 2
  logic [W-1:0] exp_a = '0, exp_b = '0;
  logic         exp_c = 1'b0;

  ncl_add_sequencer #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .init(init), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .A_dr(A_dr), .B_dr(B_dr), .cin_dr(cin_dr),
    .sum_dr(sum_dr), .cout_dr(cout_dr), .ack_comp(ack_comp), .rx_comp(rx_comp),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rail1(input logic [2*W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  function automatic bit rails_data();
    bit ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      ok &= (A_dr[2*i+1] ^ A_dr[2*i]);
      ok &= (B_dr[2*i+1] ^ B_dr[2*i]);
    end
    ok &= (cin_dr[1] ^ cin_dr[0]);
    return ok;
  endfunction

  // Behavioural NCL adder: after a chosen delay, answers a DATA wavefront with
  // the encoded sum and ack=1, and a NULL wavefront with NULL and ack=0.
  initial begin
    bit      sched = 1'b0, ph = 1'b0;
    int      cnt = 0;
    logic [W:0] res;
    sum_dr = '0; cout_dr = '0; ack_comp = 1'b0;
    forever begin
      tick();
      if (!init) begin
        sum_dr = '0; cout_dr = '0; ack_comp = 1'b0; sched = 1'b0;
      end else begin
        if (!sched && rails_data() && !ack_comp && mode != 1) begin
          sched = 1'b1; ph = 1'b1; cnt = dly_data;
        end else if (!sched && A_dr == 0 && B_dr == 0 && cin_dr == 0 && ack_comp) begin
          sched = 1'b1; ph = 1'b0; cnt = dly_null;
        end
        if (sched) begin
          if (cnt == 0) begin
            sched = 1'b0;
            if (ph) begin
              res = {1'b0, rail1(A_dr)} + {1'b0, rail1(B_dr)} + {{W{1'b0}}, cin_dr[1]};
              for (int i = 0; i < W; i++) begin
                sum_dr[2*i+1] = res[i];
                sum_dr[2*i]   = ~res[i];
              end
              cout_dr = {res[W], ~res[W]};
              if (mode == 2) sum_dr[5:4] = 2'b11;
              ack_comp = 1'b1;
            end else begin
              sum_dr = '0; cout_dr = '0; ack_comp = 1'b0;
            end
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Operand rails may only step between all-NULL and all-DATA, never mid-phase
  initial begin
    logic [4*W+1:0] prev_r = '0, cur_r;
    bit prev_d = 1'b0;
    forever begin
      tick();
      cur_r = {A_dr, B_dr, cin_dr};
      if (cur_r !== prev_r) begin
        check_val("rail_step", 32'((prev_r == 0 && rails_data()) || (cur_r == 0 && prev_d)), 1);
        if (rails_data())
          check_val("rail_ops", {rail1(A_dr), rail1(B_dr), cin_dr[1]}, {exp_a, exp_b, exp_c});
      end
      prev_r = cur_r;
      prev_d = rails_data();
    end
  end

  task automatic start_accept(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
    int n = 0;
    a = ta; b = tb2; cin = tc;
    exp_a = ta; exp_b = tb2; exp_c = tc;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_val("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic xfer(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                      input int d1, input int d2, input int rdly);
    logic [W:0] res;
    int lat = 0;
    res = {1'b0, ta} + {1'b0, tb2} + {{W{1'b0}}, tc};
    dly_data = d1; dly_null = d2;
    start_accept(ta, tb2, tc);
    check_val("busy_ready", in_ready, 0);
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check_val("latency", lat, 8 + d1 + d2);
    check_val("sum", {cout, sum}, res);
    check_val("out_state", {in_ready, rx_comp}, 0);
    for (int i = 0; i < rdly; i++) begin
      tick();
      check_val("hold", {in_ready, out_valid, cout, sum}, {2'b01, res});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("post_hs", {in_ready, out_valid}, 0);
    tick();
    check_val("ready_rise", in_ready, 1);
    $display("xfer a=%h b=%h cin=%b dly=%0d/%0d -> sum=%h cout=%b lat=%0d",
             ta, tb2, tc, d1, d2, sum, cout, lat);
  endtask

  task automatic pulse_reset();
    #2;
    init = 1'b0;
    #1;
    check_val("rst_rails", {A_dr, B_dr, cin_dr}, 0);
    check_val("rst_ctrl", {rx_comp, in_ready, out_valid}, 0);
    check_val("rst_result", {err, cout, sum}, 0);
    tick();
    tick();
    init = 1'b1;
    tick();
    check_val("rst_ready", in_ready, 1);
  endtask

  initial begin
    int n;
    init = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_val("reset_rails", {A_dr, B_dr, cin_dr}, 0);
    check_val("reset_ctrl", {rx_comp, in_ready, out_valid}, 0);
    check_val("reset_result", {err, cout, sum}, 0);
    init = 1'b1;
    tick();
    check_val("ready_after_reset", in_ready, 1);

    xfer(4'h7, 4'h9, 1'b0, 0, 0, 0);
    xfer(4'hF, 4'hF, 1'b1, 0, 0, 5);

    // Adder never completes: timeout after TMO cycles in WDATA
    mode = 1; dly_data = 0; dly_null = 0;
    start_accept(4'h5, 4'h6, 1'b0);
    tick();
    check_val("wdata_rails", 32'(rails_data()), 1);
    n = 0;
    while (err == 0 && n < 100) begin
      tick();
      n++;
    end
    check_val("tmo_cycles", n, TMO);
    check_val("tmo_err", err, 2'b01);
    check_val("tmo_state", {A_dr, B_dr, cin_dr, rx_comp, in_ready, out_valid}, 24'h00000C);
    repeat (5) tick();
    check_val("err_sticky", {err, rx_comp, in_ready, out_valid}, 6'b011100);
    $display("timeout err=%b after %0d cycles", err, n);
    pulse_reset();

    // Illegal sum digit
    mode = 2;
    start_accept(4'h5, 4'h6, 1'b0);
    n = 0;
    while (err == 0 && n < 100) begin
      tick();
      n++;
    end
    check_val("ill_cycles", n, 4);
    check_val("ill_err", err, 2'b10);
    check_val("ill_state", {A_dr, B_dr, cin_dr, rx_comp, in_ready, out_valid}, 24'h00000C);
    $display("illegal err=%b after %0d cycles", err, n);
    pulse_reset();

    // Reset while operands are DATA must clear the rails asynchronously
    mode = 1;
    start_accept(4'h5, 4'h6, 1'b1);
    tick();
    tick();
    check_val("pre_rst_data", 32'(rails_data()), 1);
    pulse_reset();
    mode = 0;
    xfer(4'h3, 4'h4, 1'b0, 0, 0, 0);

    // Reset during WNULL after a result was captured
    dly_data = 0; dly_null = 15;
    start_accept(4'h5, 4'h6, 1'b0);
    n = 0;
    while (rx_comp != 2'b11 && n < 100) begin
      tick();
      n++;
    end
    check_val("dnull_seen", rx_comp, 2'b11);
    tick();
    tick();
    pulse_reset();
    xfer(4'h3, 4'h4, 1'b0, 0, 0, 0);

    for (int t = 0; t < 100; t++)
      xfer(W'($urandom), W'($urandom), 1'($urandom),
           $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
